// File: rtl/id_decode_unit_pkg.sv
// id_decode_unit_pkg: opcode/ALU/branch encodings and the opcode-to-control decode table
package id_decode_unit_pkg;
   localparam int DEF_WORD_LEN     = 16;
   localparam int DEF_REG_ADDR_LEN = 4;
   localparam int DEF_EXE_CMD_LEN  = 4;
   typedef enum logic [3:0] {
      OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_ADDI,
      OP_LD, OP_ST, OP_BEQ, OP_BNE, OP_JMP, OP_CMP, OP_BZ, OP_RSV
   } opcode_e;
   typedef enum logic [3:0] {
      EXE_NOP, EXE_ADD, EXE_SUB, EXE_AND, EXE_OR, EXE_XOR, EXE_SLL
   } exe_cmd_e;
   typedef enum logic [1:0] {BR_NONE, BR_BEQ, BR_BNE, BR_BZ} branch_e;
   typedef struct packed {
      exe_cmd_e cmd;
      logic     wb;
      logic     mem_r;
      logic     mem_w;
      logic     imm;
      logic     st_bne;
      logic     jump;
      branch_e  br;
   } ctrl_t;
   function automatic ctrl_t decode(opcode_e op);
      ctrl_t c;
      c = '0;
      case (op)
         OP_ADD:  begin c.cmd = EXE_ADD; c.wb = 1'b1; end
         OP_SUB:  begin c.cmd = EXE_SUB; c.wb = 1'b1; end
         OP_AND:  begin c.cmd = EXE_AND; c.wb = 1'b1; end
         OP_OR:   begin c.cmd = EXE_OR;  c.wb = 1'b1; end
         OP_XOR:  begin c.cmd = EXE_XOR; c.wb = 1'b1; end
         OP_SLL:  begin c.cmd = EXE_SLL; c.wb = 1'b1; c.imm = 1'b1; end
         OP_ADDI: begin c.cmd = EXE_ADD; c.wb = 1'b1; c.imm = 1'b1; end
         OP_LD:   begin c.cmd = EXE_ADD; c.wb = 1'b1; c.mem_r = 1'b1; c.imm = 1'b1; end
         OP_ST:   begin c.cmd = EXE_ADD; c.mem_w = 1'b1; c.imm = 1'b1; c.st_bne = 1'b1; end
         OP_BEQ:  c.br = BR_BEQ;
         OP_BNE:  begin c.br = BR_BNE; c.st_bne = 1'b1; end
         OP_JMP:  c.jump = 1'b1;
         OP_CMP:  c.cmd = EXE_SUB;
         OP_BZ:   c.br = BR_BZ;
         default: c = '0;
      endcase
      return c;
   endfunction
endpackage

// File: rtl/id_cond_checker.sv
// id_cond_checker: resolves whether the selected branch condition holds
module id_cond_checker
   import id_decode_unit_pkg::*;
#(
   parameter int WORD_LEN = DEF_WORD_LEN
) (
   input  logic [WORD_LEN-1:0] reg1,
   input  logic [WORD_LEN-1:0] reg2,
   input  logic                z,
   input  logic [1:0]          branch_comm,
   output logic                condition
);
   logic w_eq;
   assign w_eq = (reg1 == reg2);
   always_comb
      condition = (branch_comm == BR_BEQ) ?  w_eq :
                  (branch_comm == BR_BNE) ? !w_eq :
                  (branch_comm == BR_BZ)  ?  z    : 1'b0;
endmodule

// File: rtl/id_decode_unit.sv
// id_decode_unit: decodes the ID-stage instruction into controls and operands, owns the CMP flag Z
module id_decode_unit
   import id_decode_unit_pkg::*;
#(
   parameter int WORD_LEN     = DEF_WORD_LEN,
   parameter int REG_ADDR_LEN = DEF_REG_ADDR_LEN,
   parameter int EXE_CMD_LEN  = DEF_EXE_CMD_LEN
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    hazard_detected_in,
   input  logic [WORD_LEN-1:0]     instruction,
   input  logic [WORD_LEN-1:0]     reg1,
   input  logic [WORD_LEN-1:0]     reg2,
   output logic [REG_ADDR_LEN-1:0] src1,
   output logic [REG_ADDR_LEN-1:0] src2_reg_file,
   output logic [REG_ADDR_LEN-1:0] src2_forw,
   output logic [REG_ADDR_LEN-1:0] customdest,
   output logic [WORD_LEN-1:0]     val1,
   output logic [WORD_LEN-1:0]     val2,
   output logic [7:0]              sll_amount,
   output logic [EXE_CMD_LEN-1:0]  exe_cmd,
   output logic                    mem_r_en,
   output logic                    mem_w_en,
   output logic                    wb_en,
   output logic                    is_imm_out,
   output logic                    st_or_bne_out,
   output logic [1:0]              branch_comm,
   output logic                    br_taken,
   output logic                    jump_enable
);
   opcode_e w_op;
   ctrl_t   w_ctrl;
   logic    w_gate;
   logic    w_cond;
   logic    r_z;
   assign w_op   = opcode_e'(instruction[15:12]);
   assign w_ctrl = decode(w_op);
   // stage enables die under a stall bubble or while reset is held low
   assign w_gate = rst & ~hazard_detected_in;
   always_comb begin
      src1          = REG_ADDR_LEN'(instruction[11:8]);
      customdest    = REG_ADDR_LEN'(instruction[11:8]);
      src2_reg_file = w_ctrl.st_bne ? REG_ADDR_LEN'(instruction[11:8]) : REG_ADDR_LEN'(instruction[7:4]);
      src2_forw     = w_ctrl.imm ? '0 : REG_ADDR_LEN'(instruction[7:4]);
      val1          = reg1;
      val2          = w_ctrl.imm ? {{(WORD_LEN-8){instruction[7]}}, instruction[7:0]} : reg2;
      sll_amount    = instruction[7:0];
      is_imm_out    = w_ctrl.imm;
      st_or_bne_out = w_ctrl.st_bne;
      branch_comm   = w_ctrl.br;
      exe_cmd       = w_gate ? EXE_CMD_LEN'(w_ctrl.cmd) : '0;
      wb_en         = w_gate & w_ctrl.wb;
      mem_r_en      = w_gate & w_ctrl.mem_r;
      mem_w_en      = w_gate & w_ctrl.mem_w;
      jump_enable   = w_gate & w_ctrl.jump;
      br_taken      = w_gate & w_cond;
   end
   id_cond_checker #(.WORD_LEN(WORD_LEN)) u_cond (
      .reg1        (reg1),
      .reg2        (reg2),
      .z           (r_z),
      .branch_comm (w_ctrl.br),
      .condition   (w_cond)
   );
   always_ff @(posedge clk)
      if (!rst)
         r_z <= 1'b0;
      else if (w_op == OP_CMP && !hazard_detected_in)
         r_z <= (reg1 == reg2);
endmodule

// File: tb/tb_id_decode_unit.sv
// tb_id_decode_unit: directed test-plan checks plus randomized per-cycle comparison against an opcode-table model
module tb_id_decode_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        hazard_detected_in = 1'b0;
   logic [15:0] instruction = '0;
   logic [15:0] reg1 = '0;
   logic [15:0] reg2 = '0;
   logic [3:0]  src1, src2_reg_file, src2_forw, customdest;
   logic [15:0] val1, val2;
   logic [7:0]  sll_amount;
   logic [3:0]  exe_cmd;
   logic        mem_r_en, mem_w_en, wb_en, is_imm_out, st_or_bne_out;
   logic [1:0]  branch_comm;
   logic        br_taken, jump_enable;
   int          errors = 0;
   int          checks = 0;
   logic        m_z = 1'b0;
   logic        run_cmp = 1'b0;

   // opcode tables: bit/nibble n describes opcode n
   localparam logic [63:0] CMD_TBL = 64'h0020_0011_1654_3210;
   localparam logic [15:0] WB_OPS  = 16'h01FE;
   localparam logic [15:0] IMM_OPS = 16'h03C0;
   localparam logic [15:0] MR_OPS  = 16'h0100;
   localparam logic [15:0] MW_OPS  = 16'h0200;
   localparam logic [15:0] SB_OPS  = 16'h0A00;
   localparam logic [15:0] JMP_OPS = 16'h1000;

   id_decode_unit dut (
      .clk(clk), .rst(rst), .hazard_detected_in(hazard_detected_in),
      .instruction(instruction), .reg1(reg1), .reg2(reg2),
      .src1(src1), .src2_reg_file(src2_reg_file), .src2_forw(src2_forw), .customdest(customdest),
      .val1(val1), .val2(val2), .sll_amount(sll_amount), .exe_cmd(exe_cmd),
      .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en),
      .is_imm_out(is_imm_out), .st_or_bne_out(st_or_bne_out),
      .branch_comm(branch_comm), .br_taken(br_taken), .jump_enable(jump_enable)
   );

   always #5 clk = ~clk;

   function automatic logic [68:0] model(logic [15:0] ins, logic [15:0] r1, logic [15:0] r2,
                                         logic haz, logic rs, logic z);
      int          op;
      logic        g, imm, sb, cond;
      logic [1:0]  bc;
      op   = int'(ins[15:12]);
      g    = rs & ~haz;
      imm  = IMM_OPS[op];
      sb   = SB_OPS[op];
      bc   = (op == 10) ? 2'd1 : (op == 11) ? 2'd2 : (op == 14) ? 2'd3 : 2'd0;
      cond = (bc == 2'd1) ? (r1 == r2) : (bc == 2'd2) ? (r1 != r2) : (bc == 2'd3) ? z : 1'b0;
      return {ins[11:8], sb ? ins[11:8] : ins[7:4], imm ? 4'd0 : ins[7:4], ins[11:8],
              r1, imm ? {{8{ins[7]}}, ins[7:0]} : r2, ins[7:0],
              g ? CMD_TBL[op*4 +: 4] : 4'd0,
              g & MR_OPS[op], g & MW_OPS[op], g & WB_OPS[op], imm, sb, bc,
              g & cond, g & JMP_OPS[op]};
   endfunction

   function automatic logic [68:0] dut_bundle();
      return {src1, src2_reg_file, src2_forw, customdest, val1, val2, sll_amount, exe_cmd,
              mem_r_en, mem_w_en, wb_en, is_imm_out, st_or_bne_out, branch_comm, br_taken, jump_enable};
   endfunction

   task automatic chk(string nm, logic [68:0] act, logic [68:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // model Z: CMP result captured at the edge unless stalled, cleared by reset
   always @(posedge clk)
      if (!rst) m_z <= 1'b0;
      else if (instruction[15:12] == 4'd13 && !hazard_detected_in) m_z <= (reg1 == reg2);

   always @(negedge clk)
      if (run_cmp)
         chk("model", dut_bundle(), model(instruction, reg1, reg2, hazard_detected_in, rst, m_z));

   task automatic apply(logic [15:0] ins, logic [15:0] r1, logic [15:0] r2, logic haz, logic rs);
      @(posedge clk);
      #1;
      instruction = ins; reg1 = r1; reg2 = r2; hazard_detected_in = haz; rst = rs;
      #2;
   endtask

   initial begin
      apply(16'h1340, 16'h0001, 16'h0005, 1'b0, 1'b0);
      run_cmp = 1'b1;
      chk("reset_gate", {wb_en, exe_cmd}, 5'h00);
      apply(16'h1340, 16'h0001, 16'h0005, 1'b0, 1'b1);
      chk("add_ctrl", {wb_en, exe_cmd, is_imm_out}, 6'b1_0001_0);
      chk("add_val2", val2, 16'h0005);
      chk("add_src2", {src2_forw, src2_reg_file}, 8'h44);
      apply(16'h73F0, 16'h0001, 16'h0005, 1'b0, 1'b1);
      chk("addi", {val2, src2_forw, is_imm_out}, {16'hFFF0, 4'h0, 1'b1});
      apply(16'h9580, 16'h0001, 16'h0005, 1'b0, 1'b1);
      chk("st_ctrl", {mem_w_en, wb_en, src2_reg_file}, {1'b1, 1'b0, 4'h5});
      chk("st_val2", val2, 16'hFF80);
      apply(16'hA120, 16'h0007, 16'h0007, 1'b0, 1'b1);
      chk("beq_eq", br_taken, 1'b1);
      apply(16'hA120, 16'h0007, 16'h0008, 1'b0, 1'b1);
      chk("beq_ne", br_taken, 1'b0);
      apply(16'hB120, 16'h0007, 16'h0008, 1'b0, 1'b1);
      chk("bne_taken", {br_taken, branch_comm}, 3'b1_10);
      apply(16'hB120, 16'h0007, 16'h0008, 1'b1, 1'b1);
      chk("bne_hazard", {br_taken, wb_en, mem_r_en, mem_w_en, jump_enable, exe_cmd, branch_comm}, 11'b0_0000_0000_10);
      apply(16'hD120, 16'h0003, 16'h0003, 1'b0, 1'b1);
      chk("cmp_cmd", exe_cmd, 4'h2);
      apply(16'hE000, 16'h0001, 16'h0002, 1'b0, 1'b1);
      chk("bz_after_cmp", br_taken, 1'b1);
      apply(16'hD120, 16'h0003, 16'h0004, 1'b1, 1'b1);
      apply(16'hE000, 16'h0001, 16'h0002, 1'b0, 1'b1);
      chk("bz_cmp_stalled", br_taken, 1'b1);
      apply(16'hE000, 16'h0001, 16'h0002, 1'b0, 1'b0);
      chk("bz_in_reset", {br_taken, exe_cmd}, 5'h00);
      apply(16'hE000, 16'h0001, 16'h0002, 1'b0, 1'b1);
      chk("bz_after_reset", {br_taken, branch_comm}, 3'b0_11);
      apply(16'hC000, 16'h0001, 16'h0002, 1'b0, 1'b1);
      chk("jmp", jump_enable, 1'b1);
      for (int i = 0; i < 3000; i++) begin
         logic [15:0] a, b;
         a = 16'($urandom);
         b = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
         apply(16'($urandom), a, b, $urandom_range(0, 4) == 0, $urandom_range(0, 19) != 0);
      end
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
